// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// IF-stage dynamic branch predictor. It uses a direct-mapped branch target
// buffer (BTB), and each entry holds a 2-bit saturating counter. The lookup
// side is purely combinational, so it predicts for the current fetch PC with
// zero latency. The EX stage sends back the resolved branch outcome, which
// trains the tables and drives the misprediction flush and the corrected PC.
//
// Ports:
//   CLK              in   clock, rising edge
//   RESET            in   synchronous, active-high; beats any update
//   PC_IF     [31:0] in   fetch PC
//   PREDICT_TAKEN    out  BTB hit and counter MSB set
//   NEXT_PC   [31:0] out  predicted next fetch PC
//   UPDATE_EN        in   EX holds a valid branch/jump this cycle
//   PC_EX     [31:0] in   PC of the resolving instruction
//   TARGET_EX [31:0] in   computed branch/jump target
//   BRANCH_TAKEN     in   resolved outcome (1 for JAL/JALR)
//   PREDICTED_EX     in   PREDICT_TAKEN piped down from IF
//   PREDICTED_PC_EX  in   NEXT_PC piped down from IF
//   MISPREDICT       out  flush request to the hazard unit
//   CORRECT_PC[31:0] out  PC to redirect fetch to
//   MISS_COUNT[31:0] out  saturating count of mispredictions since reset
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC_IF,
  output logic        PREDICT_TAKEN,
  output logic [31:0] NEXT_PC,
  input  logic        UPDATE_EN,
  input  logic [31:0] PC_EX,
  input  logic [31:0] TARGET_EX,
  input  logic        BRANCH_TAKEN,
  input  logic        PREDICTED_EX,
  input  logic [31:0] PREDICTED_PC_EX,
  output logic        MISPREDICT,
  output logic [31:0] CORRECT_PC,
  output logic [31:0] MISS_COUNT
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // BTB storage. The lookup must read it asynchronously, so it is kept in
  // registers and not in block RAM.
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [31:0] miss_count_q;
  logic [31:0] miss_count_d;

  // The low two PC bits are always zero for aligned instructions.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC_IF[1:0], PC_EX[1:0]};

  // -------------------------------------------------------------------------
  // Fetch-side lookup
  // -------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] idx_if;
  logic [TAG_BITS-1:0]   tag_if;
  logic                  hit_if;

  assign idx_if = PC_IF[INDEX_BITS+1:2];
  assign tag_if = PC_IF[31:INDEX_BITS+2];
  // This path reads the table as it stands before any update on this edge.
  // It does not bypass a write in the same cycle.
  assign hit_if        = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
  assign PREDICT_TAKEN = hit_if && ctr_q[idx_if][1];
  assign NEXT_PC       = PREDICT_TAKEN ? target_q[idx_if] : (PC_IF + 32'd4);

  // -------------------------------------------------------------------------
  // EX-side resolution
  // -------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] idx_ex;
  logic [TAG_BITS-1:0]   tag_ex;
  logic                  hit_ex;

  assign idx_ex = PC_EX[INDEX_BITS+1:2];
  assign tag_ex = PC_EX[31:INDEX_BITS+2];
  assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

  // A taken branch that was predicted taken can still mispredict when the
  // predicted target was stale. One example is a JALR to a new address.
  assign MISPREDICT = UPDATE_EN &&
                      ((BRANCH_TAKEN != PREDICTED_EX) ||
                       (BRANCH_TAKEN && (PREDICTED_PC_EX != TARGET_EX)));
  assign CORRECT_PC = BRANCH_TAKEN ? TARGET_EX : (PC_EX + 32'd4);

  // -------------------------------------------------------------------------
  // New contents for the entry at idx_ex
  // -------------------------------------------------------------------------
  logic [1:0]  ctr_d;
  logic [31:0] target_d;

  always_comb begin
    // A miss allocates a new entry. It starts weakly biased toward the
    // outcome just seen.
    ctr_d    = BRANCH_TAKEN ? 2'b10 : 2'b01;
    target_d = TARGET_EX;
    if (hit_ex) begin
      if (BRANCH_TAKEN) begin
        ctr_d = (ctr_q[idx_ex] == 2'b11) ? 2'b11 : (ctr_q[idx_ex] + 2'b01);
      end else begin
        ctr_d    = (ctr_q[idx_ex] == 2'b00) ? 2'b00 : (ctr_q[idx_ex] - 2'b01);
        // A not-taken outcome keeps the last known taken target.
        target_d = target_q[idx_ex];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (UPDATE_EN) begin
      valid_q[idx_ex]  <= 1'b1;
      tag_q[idx_ex]    <= tag_ex;
      target_q[idx_ex] <= target_d;
      ctr_q[idx_ex]    <= ctr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Misprediction counter. It saturates at all-ones and never wraps.
  // -------------------------------------------------------------------------
  always_comb begin
    miss_count_d = miss_count_q;
    if (MISPREDICT && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      miss_count_q <= '0;
    end else begin
      miss_count_q <= miss_count_d;
    end
  end

  assign MISS_COUNT = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Table-driven bench for branch_predictor. Each record holds one cycle of
// stimulus and the outputs the predictor must show in that cycle. The
// outputs are combinational, and MISS_COUNT is the value held before the
// cycle's rising edge. Expected values go into a scoreboard queue when a
// record is driven. They are popped and compared when the outputs are
// sampled in the middle of the low clock phase.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PC_IF;
  logic        PREDICT_TAKEN;
  logic [31:0] NEXT_PC;
  logic        UPDATE_EN;
  logic [31:0] PC_EX;
  logic [31:0] TARGET_EX;
  logic        BRANCH_TAKEN;
  logic        PREDICTED_EX;
  logic [31:0] PREDICTED_PC_EX;
  logic        MISPREDICT;
  logic [31:0] CORRECT_PC;
  logic [31:0] MISS_COUNT;

  branch_predictor #(.INDEX_BITS(4)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .PC_IF           (PC_IF),
    .PREDICT_TAKEN   (PREDICT_TAKEN),
    .NEXT_PC         (NEXT_PC),
    .UPDATE_EN       (UPDATE_EN),
    .PC_EX           (PC_EX),
    .TARGET_EX       (TARGET_EX),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .PREDICTED_EX    (PREDICTED_EX),
    .PREDICTED_PC_EX (PREDICTED_PC_EX),
    .MISPREDICT      (MISPREDICT),
    .CORRECT_PC      (CORRECT_PC),
    .MISS_COUNT      (MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [31:0] pc_if;
    logic        upd;
    logic [31:0] pc_ex;
    logic [31:0] tgt;
    logic        taken;
    logic        pred;
    logic [31:0] ppc;
    logic        e_pt;
    logic [31:0] e_np;
    logic        e_mis;
    logic [31:0] e_cpc;
    logic [31:0] e_mc;
  } vec_t;

  typedef struct {
    int          id;
    logic        pt;
    logic [31:0] np;
    logic        mis;
    logic [31:0] cpc;
    logic [31:0] mc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic rst, input logic [31:0] pc_if,
                              input logic upd, input logic [31:0] pc_ex,
                              input logic [31:0] tgt, input logic taken,
                              input logic pred, input logic [31:0] ppc,
                              input logic e_pt, input logic [31:0] e_np,
                              input logic e_mis, input logic [31:0] e_cpc,
                              input logic [31:0] e_mc);
    vec_t v;
    v.rst = rst; v.pc_if = pc_if; v.upd = upd; v.pc_ex = pc_ex; v.tgt = tgt;
    v.taken = taken; v.pred = pred; v.ppc = ppc;
    v.e_pt = e_pt; v.e_np = e_np; v.e_mis = e_mis; v.e_cpc = e_cpc; v.e_mc = e_mc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Drive one record at the falling edge, then sample 2 ns later. The next
  // rising edge comes 3 ns after the sample.
  task automatic apply(input vec_t v, input int id);
    exp_t e;
    exp_t got;
    @(negedge CLK);
    RESET           = v.rst;
    PC_IF           = v.pc_if;
    UPDATE_EN       = v.upd;
    PC_EX           = v.pc_ex;
    TARGET_EX       = v.tgt;
    BRANCH_TAKEN    = v.taken;
    PREDICTED_EX    = v.pred;
    PREDICTED_PC_EX = v.ppc;
    e.id = id; e.pt = v.e_pt; e.np = v.e_np; e.mis = v.e_mis;
    e.cpc = v.e_cpc; e.mc = v.e_mc;
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", id);
    end else begin
      got = sb.pop_front();
      $display("vec %0d rst=%b pc_if=%h upd=%b pc_ex=%h tgt=%h tk=%b -> pt=%b np=%h mis=%b cpc=%h mc=%0d",
               got.id, v.rst, v.pc_if, v.upd, v.pc_ex, v.tgt, v.taken,
               PREDICT_TAKEN, NEXT_PC, MISPREDICT, CORRECT_PC, MISS_COUNT);
      check("PREDICT_TAKEN", got.id, {31'd0, PREDICT_TAKEN}, {31'd0, got.pt});
      check("NEXT_PC",       got.id, NEXT_PC,               got.np);
      check("MISPREDICT",    got.id, {31'd0, MISPREDICT},    {31'd0, got.mis});
      check("CORRECT_PC",    got.id, CORRECT_PC,            got.cpc);
      check("MISS_COUNT",    got.id, MISS_COUNT,            got.mc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Columns: rst pc_if upd pc_ex tgt taken pred ppc | pt np mis cpc mc
    // Indices at INDEX_BITS=4: 0x100/0x140/0x180 -> idx 0, 0x20 -> idx 8.
    add(0, 32'h100, 0, 32'h0,   32'h0,  0, 0, 32'h0,   0, 32'h104, 0, 32'h4,   0); //  0 reset state
    add(0, 32'h100, 1, 32'h100, 32'h80, 1, 0, 32'h104, 0, 32'h104, 1, 32'h80,  0); //  1 first taken, allocate 10
    add(0, 32'h100, 0, 32'h100, 32'h0,  0, 0, 32'h0,   1, 32'h80,  0, 32'h104, 1); //  2 predicts taken
    add(0, 32'h100, 1, 32'h100, 32'h80, 1, 1, 32'h80,  1, 32'h80,  0, 32'h80,  1); //  3 -> 11
    add(0, 32'h100, 1, 32'h100, 32'h80, 1, 1, 32'h80,  1, 32'h80,  0, 32'h80,  1); //  4 stays 11
    add(0, 32'h100, 1, 32'h100, 32'h80, 0, 1, 32'h80,  1, 32'h80,  1, 32'h104, 1); //  5 not taken -> 10
    add(0, 32'h100, 0, 32'h100, 32'h0,  0, 0, 32'h0,   1, 32'h80,  0, 32'h104, 2); //  6 still taken
    add(0, 32'h100, 1, 32'h100, 32'h80, 0, 1, 32'h80,  1, 32'h80,  1, 32'h104, 2); //  7 -> 01, old view
    add(0, 32'h100, 0, 32'h100, 32'h0,  0, 0, 32'h0,   0, 32'h104, 0, 32'h104, 3); //  8 not taken now
    add(0, 32'h100, 1, 32'h100, 32'h80, 0, 0, 32'h104, 0, 32'h104, 0, 32'h104, 3); //  9 -> 00
    add(0, 32'h100, 1, 32'h100, 32'h80, 0, 0, 32'h104, 0, 32'h104, 0, 32'h104, 3); // 10 stays 00
    add(0, 32'h100, 1, 32'h100, 32'h80, 1, 0, 32'h104, 0, 32'h104, 1, 32'h80,  3); // 11 -> 01
    add(0, 32'h100, 0, 32'h100, 32'h0,  0, 0, 32'h0,   0, 32'h104, 0, 32'h104, 4); // 12 01 not taken
    add(0, 32'h100, 1, 32'h100, 32'h80, 1, 0, 32'h104, 0, 32'h104, 1, 32'h80,  4); // 13 -> 10
    add(0, 32'h100, 1, 32'h100, 32'h90, 1, 1, 32'h80,  1, 32'h80,  1, 32'h90,  5); // 14 target mismatch
    add(0, 32'h100, 0, 32'h100, 32'h0,  0, 0, 32'h0,   1, 32'h90,  0, 32'h104, 6); // 15 new target
    add(0, 32'h140, 1, 32'h140, 32'h200,1, 0, 32'h144, 0, 32'h144, 1, 32'h200, 6); // 16 alias replaces
    add(0, 32'h100, 0, 32'h0,   32'h0,  0, 0, 32'h0,   0, 32'h104, 0, 32'h4,   7); // 17 0x100 misses
    add(0, 32'h140, 0, 32'h0,   32'h0,  0, 0, 32'h0,   1, 32'h200, 0, 32'h4,   7); // 18 0x140 hits
    add(0, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 7); // 19 PC+4 wraps
    add(0, 32'h140, 0, 32'h10,  32'h300,1, 0, 32'h0,   1, 32'h200, 0, 32'h300, 7); // 20 no update, no flush
    add(1, 32'h140, 1, 32'h180, 32'h400,1, 0, 32'h184, 1, 32'h200, 1, 32'h400, 7); // 21 reset beats update
    add(0, 32'h180, 0, 32'h0,   32'h0,  0, 0, 32'h0,   0, 32'h184, 0, 32'h4,   0); // 22 no allocation
    add(0, 32'h140, 0, 32'h0,   32'h0,  0, 0, 32'h0,   0, 32'h144, 0, 32'h4,   0); // 23 table cleared
    add(0, 32'h20,  1, 32'h20,  32'h60, 0, 0, 32'h24,  0, 32'h24,  0, 32'h24,  0); // 24 allocate not-taken 01
    add(0, 32'h20,  0, 32'h0,   32'h0,  0, 0, 32'h0,   0, 32'h24,  0, 32'h4,   0); // 25 01 not taken
    add(0, 32'h20,  1, 32'h20,  32'h60, 1, 0, 32'h24,  0, 32'h24,  1, 32'h60,  0); // 26 hit -> 10
    add(0, 32'h20,  0, 32'h0,   32'h0,  0, 0, 32'h0,   1, 32'h60,  0, 32'h4,   1); // 27 predicts 0x60

    // Initial reset for two cycles with quiet inputs.
    RESET = 1'b1; PC_IF = '0; UPDATE_EN = 1'b0; PC_EX = '0; TARGET_EX = '0;
    BRANCH_TAKEN = 1'b0; PREDICTED_EX = 1'b0; PREDICTED_PC_EX = '0;
    repeat (2) @(posedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Hand-written sequence: back-to-back flushes count once per clock.
    // Entry 8 (0x20) holds ctr 10 and target 0x60 at this point.
    begin
      vec_t v;
      int   base;
      base = vecs.size();
      for (int k = 0; k < 3; k++) begin
        // Each cycle predicts the wrong target, so every cycle flushes.
        v.rst = 0; v.pc_if = 32'h20; v.upd = 1; v.pc_ex = 32'h20;
        v.tgt = 32'h60; v.taken = 1; v.pred = 1; v.ppc = 32'h64;
        v.e_pt = 1; v.e_np = 32'h60; v.e_mis = 1; v.e_cpc = 32'h60;
        v.e_mc = 32'(1 + k);
        apply(v, base + k);
      end
      v.rst = 0; v.pc_if = 32'h20; v.upd = 0; v.pc_ex = 32'h0; v.tgt = 32'h0;
      v.taken = 0; v.pred = 0; v.ppc = 32'h0;
      v.e_pt = 1; v.e_np = 32'h60; v.e_mis = 0; v.e_cpc = 32'h4; v.e_mc = 32'd4;
      apply(v, base + 3);
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
